// File: rtl/mul_pkg.sv
// mul_pkg: shared FSM state type and default operand width for mul_seq.
package mul_pkg;
  localparam int MUL_WIDTH = 4;
  typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/mul_seq.sv
// mul_seq: sequential shift-and-add multiply-accumulate, P = A*B + C over unsigned operands.
module mul_seq
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [WIDTH-1:0]   C,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] P
);
  localparam int CW = $clog2(WIDTH);
  state_t             state;
  logic [2*WIDTH-1:0] acc, mcand, acc_next;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      count;
  always_comb acc_next = mplier[0] ? acc + mcand : acc;
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      P      <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          acc    <= {{WIDTH{1'b0}}, C};
          mcand  <= {{WIDTH{1'b0}}, A};
          mplier <= B;
          count  <= '0;
          busy   <= 1'b1;
          state  <= RUN;
        end
      end else begin
        acc    <= acc_next;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        count  <= count + CW'(1);
        // last step: publish the result straight from the adder
        if (count == CW'(WIDTH - 1)) begin
          P     <= acc_next;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: scoreboard bench; an independent accept model queues expected results, a monitor checks each done.
module tb_mul_seq;
  import mul_pkg::*;
  localparam int W = MUL_WIDTH;
  logic           clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [W-1:0]   A = '0, B = '0, C = '0;
  logic           busy, done;
  logic [2*W-1:0] P;
  int total = 0, bad = 0, cyc = 0;
  typedef struct { logic [2*W-1:0] p; int at; } exp_t;
  exp_t q[$];
  mul_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .start(start), .A(A), .B(B), .C(C),
                            .busy(busy), .done(done), .P(P));
  always #5 clk = ~clk;
  initial begin : model
    bit mb = 0;
    int mend = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        mb = 0;
        q.delete();
      end else if (mb) begin
        if (cyc == mend) mb = 0;
      end else if (start) begin
        q.push_back('{p: (2*W)'(A) * (2*W)'(B) + (2*W)'(C), at: cyc + W});
        mb = 1;
        mend = cyc + W;
      end
    end
  end
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (busy && done) begin
        bad++;
        $display("FAIL busy_done_overlap cyc=%0d busy=%b done=%b required not both high", cyc, busy, done);
      end
      if (done) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_done cyc=%0d P=%0d required no done", cyc, P);
        end else begin
          e = q.pop_front();
          if (P !== e.p || cyc != e.at) begin
            bad++;
            $display("FAIL result cyc=%0d P=%0d required P=%0d at cyc=%0d", cyc, P, e.p, e.at);
          end
        end
      end
    end
  end
  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%0d required=%0d", name, act, req);
    end
  endtask
  task automatic issue(input int a, input int b, input int c);
    start = 1'b1;
    A = W'(a);
    B = W'(b);
    C = W'(c);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (W) @(posedge clk);
    #1;
  endtask
  int vec[7][3] = '{'{4,2,1}, '{5,3,0}, '{2,4,2}, '{1,3,2}, '{15,15,15}, '{0,0,0}, '{7,0,8}};
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 2*W'(busy), 0);
    check("reset_done", 2*W'(done), 0);
    check("reset_P", P, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    foreach (vec[i]) issue(vec[i][0], vec[i][1], vec[i][2]);
    check("hold_P_after_idle", P, 8);
    // second start mid-RUN must be ignored
    start = 1'b1; A = 3; B = 3; C = 0;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 start = 1'b1; A = 15; B = 15; C = 0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (W + 2) @(posedge clk);
    #1;
    check("busy_ignore_P", P, 9);
    // back-to-back with start held and operands changing each cycle
    start = 1'b1;
    for (int i = 0; i < 3 * (W + 1) + 1; i++) begin
      A = W'(i + 1);
      B = W'(2 * i + 3);
      C = W'(i * 5);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    repeat (W + 2) @(posedge clk);
    #1;
    // reset in the middle of a run
    start = 1'b1; A = 9; B = 9; C = 0;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("midrst_busy", 2*W'(busy), 0);
    check("midrst_P", P, 0);
    repeat (W + 2) @(posedge clk);
    #1;
    check("midrst_P_stays", P, 0);
    issue(2, 3, 1);
    @(negedge clk);
    check("after_rst_P", P, 7);
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 16; c++)
          issue(a, b, c);
    repeat (W + 2) @(posedge clk);
    #1;
    check("no_pending_results", 2*W'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
